// File: rtl/hs_sink_pkg.sv
// rtl/hs_sink_pkg.sv - shared FSM state and merged-FIFO entry types for hs_sink_array
package hs_sink_pkg;

    // Entry fields are sized for the largest supported build: N_CH <= 16, DATA_W <= 32.
    localparam int HS_CHAN_W_MAX = 4;
    localparam int HS_DATA_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } hs_state_e;

    typedef struct packed {
        logic [HS_CHAN_W_MAX-1:0] chan;
        logic [HS_DATA_W_MAX-1:0] data;
    } hs_fifo_ent_t;

endpackage

// File: rtl/hs_rr_arb.sv
// rtl/hs_rr_arb.sv - round-robin arbiter, one-hot grant, search starts after the last grantee
module hs_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_d    = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hs_sink_array.sv
// rtl/hs_sink_array.sv - per-channel req/ack sinks; merged output FIFO when HS_SINK_FIFO_EN is defined
module hs_sink_array
    import hs_sink_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int DATA_W = 8,
    parameter int DLY_W  = 4,
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DLY_W-1:0]                    ack_dly,
    input  logic [N_CH-1:0]                     req,
    input  logic [N_CH*DATA_W-1:0]              data,
    output logic [N_CH-1:0]                     ack,
    output logic [N_CH*CNT_W-1:0]               xfer_cnt,
    output logic [N_CH*DATA_W-1:0]              last_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_chan,
    output logic [DATA_W-1:0]                   out_data
);

    localparam int CHAN_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] elig;
    logic [N_CH-1:0] gnt;
    logic [N_CH-1:0] in_ack;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        hs_state_e         st_q;
        hs_state_e         st_d;
        logic [DLY_W-1:0]  cnt_q;
        logic [DLY_W-1:0]  cnt_d;
        logic [CNT_W-1:0]  xfer_q;
        logic [DATA_W-1:0] last_q;
        logic              expiring;

        // The wait expires on the cycle the counter reaches zero, so ACK lands ack_dly+1 cycles after req.
        assign expiring  = (cnt_q <= DLY_W'(1));
        assign elig[i]   = req[i] && (((st_q == IDLE) && (ack_dly == '0)) ||
                                      ((st_q == WAIT) && expiring));
        assign in_ack[i] = (st_q == ACK);

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            case (st_q)
                IDLE: begin
                    if (req[i]) begin
                        cnt_d = ack_dly;
                        st_d  = gnt[i] ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!req[i]) begin
                        st_d = IDLE;
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - DLY_W'(1);
                        end
                        if (gnt[i]) begin
                            st_d = ACK;
                        end
                    end
                end
                ACK:     st_d = IDLE;
                default: st_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                xfer_q <= '0;
                last_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                if (st_q == ACK) begin
                    xfer_q <= xfer_q + CNT_W'(1);
                    last_q <= data[i*DATA_W +: DATA_W];
                end
            end
        end

        assign xfer_cnt[i*CNT_W +: CNT_W]    = xfer_q;
        assign last_data[i*DATA_W +: DATA_W] = last_q;
    end

    assign ack = in_ack;

`ifdef HS_SINK_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    hs_fifo_ent_t mem [DEPTH];
    hs_fifo_ent_t push_ent;
    hs_fifo_ent_t head;
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [AW:0]  level;
    logic         push;
    logic         pop;
    logic         room;
    logic         unused_head;

    assign level = wr_q - rd_q;
    assign push  = |in_ack;
    assign pop   = out_valid && out_ready;
    // Count the push still in ACK so a grant can never overfill the FIFO.
    assign room  = ({1'b0, level} + {{(AW+1){1'b0}}, push}) < (AW+2)'(DEPTH);

    hs_rr_arb #(.N(N_CH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (room),
        .req   (elig),
        .gnt   (gnt)
    );

    always_comb begin
        push_ent = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (in_ack[k]) begin
                push_ent.chan = HS_CHAN_W_MAX'(k);
                push_ent.data = HS_DATA_W_MAX'(data[k*DATA_W +: DATA_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q[AW-1:0]] <= push_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    assign head        = mem[rd_q[AW-1:0]];
    assign out_valid   = (level != '0);
    assign out_chan    = head.chan[CHAN_W-1:0];
    assign out_data    = head.data[DATA_W-1:0];
    assign unused_head = ^head;
`else
    logic unused_ready;

    assign gnt          = elig;
    assign out_valid    = 1'b0;
    assign out_chan     = '0;
    assign out_data     = '0;
    assign unused_ready = out_ready;
`endif

endmodule

// File: tb/tb_hs_sink_array.sv
// tb/tb_hs_sink_array.sv - self-checking bench for hs_sink_array (N_CH=2, CNT_W=4, DEPTH=4)
module tb_hs_sink_array;

    localparam int N_CH   = 2;
    localparam int DATA_W = 8;
    localparam int DLY_W  = 4;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [DLY_W-1:0]         ack_dly;
    logic [N_CH-1:0]          req;
    logic [N_CH*DATA_W-1:0]   data;
    logic [N_CH-1:0]          ack;
    logic [N_CH*CNT_W-1:0]    xfer_cnt;
    logic [N_CH*DATA_W-1:0]   last_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [0:0]               out_chan;
    logic [DATA_W-1:0]        out_data;

    hs_sink_array #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DLY_W(DLY_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ack_dly(ack_dly), .req(req), .data(data),
        .ack(ack), .xfer_cnt(xfer_cnt), .last_data(last_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        int         dly;
        logic [7:0] d;
        int         drop;
        int         exp_ack;
    } vec_t;

    vec_t       vt [8];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         m_cnt [N_CH];
    logic [7:0] m_last [N_CH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_cnt[k]  = 0;
            m_last[k] = 8'h00;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One request on one channel; the expected ack cycle comes from the caller.
    task automatic run_txn(input int ch, input int dly, input logic [7:0] d,
                           input int drop, input int exp_ack);
        int ack_at;
        int n_ack;
        ack_at = 0;
        n_ack  = 0;
        ack_dly = DLY_W'(dly);
        data[ch*8 +: 8] = d;
        req[ch] = 1'b1;
        if (exp_ack != 0) begin
            m_cnt[ch]++;
            m_last[ch] = d;
        end
        for (int c = 1; c <= dly + 4; c++) begin
            @(negedge clk);
            if (ack[ch]) begin
                n_ack++;
                if (ack_at == 0) ack_at = c;
                req[ch] = 1'b0;
            end
`ifdef HS_SINK_FIFO_EN
            if (ack_at != 0 && c == ack_at + 1) begin
                chk("fifo_valid", 32'(out_valid), 32'd1);
                chk("fifo_chan", 32'(out_chan), 32'(ch));
                chk("fifo_data", 32'(out_data), 32'(d));
            end
`endif
            if (c == drop) req[ch] = 1'b0;
        end
        req[ch] = 1'b0;
        chk("txn_ack_cycle", 32'(ack_at), 32'(exp_ack));
        chk("txn_ack_count", 32'(n_ack), 32'(exp_ack != 0));
        chk("txn_xfer_cnt", 32'(xfer_cnt[ch*4 +: 4]), 32'(m_cnt[ch] % 16));
        chk("txn_last_data", 32'(last_data[ch*8 +: 8]), 32'(m_last[ch]));
`ifndef HS_SINK_FIFO_EN
        chk("no_fifo_valid", 32'(out_valid), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         found;
        int         ch;
        int         dly;
        int         drop;
        int         exp;
        int         resumed;
        logic [7:0] d;
        logic [5:0] pattern;
        logic [8:0] ent;
        int         acks [$];
        logic [8:0] sb [$];

        vt[0] = '{0,  0, 8'h11, 0,  1};
        vt[1] = '{1,  3, 8'hA5, 0,  4};
        vt[2] = '{0,  5, 8'h5A, 2,  0};
        vt[3] = '{0,  5, 8'h66, 0,  6};
        vt[4] = '{1, 15, 8'hFF, 0, 16};
        vt[5] = '{1,  1, 8'h3C, 1,  0};
        vt[6] = '{1,  1, 8'hC3, 0,  2};
        vt[7] = '{0,  2, 8'h80, 0,  3};

        rst_n = 1'b0;
        req = '0;
        data = '0;
        ack_dly = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_last_data", 32'(last_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i].ch, vt[i].dly, vt[i].d, vt[i].drop, vt[i].exp_ack);
        end

        // ack_dly=0 with req held for six samples: acks on alternate cycles
        ack_dly = '0;
        data[7:0] = 8'h77;
        req[0] = 1'b1;
        pattern = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            pattern[c-1] = ack[0];
            if (c == 6) req[0] = 1'b0;
        end
        @(negedge clk);
        m_cnt[0] += 3;
        m_last[0] = 8'h77;
        chk("hold_ack_pattern", 32'(pattern), 32'b010101);
        chk("hold_xfer_cnt", 32'(xfer_cnt[3:0]), 32'(m_cnt[0] % 16));
        chk("hold_last_data", 32'(last_data[7:0]), 32'h77);

`ifdef HS_SINK_FIFO_EN
        // Back-pressure: four acks alternate, then both channels stall until drained
        pulse_reset();
        out_ready = 1'b0;
        ack_dly = '0;
        data = {8'hC3, 8'h3C};
        req = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < N_CH; k++) begin
                if (ack[k]) begin
                    acks.push_back(k);
                    sb.push_back({1'(k), data[k*8 +: 8]});
                    m_cnt[k]++;
                end
            end
        end
        chk("bp_ack_total", 32'(acks.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < acks.size()) chk("bp_ack_order", 32'(acks[j]), 32'(j % 2));
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        resumed = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            for (int k = 0; k < N_CH; k++) begin
                if (ack[k]) begin
                    sb.push_back({1'(k), data[k*8 +: 8]});
                    m_cnt[k]++;
                    resumed++;
                end
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("drain_unexpected_entry", 32'd1, 32'd0);
                end else begin
                    ent = sb.pop_front();
                    chk("drain_entry", 32'({out_chan, out_data}), 32'(ent));
                end
            end
            if (c == 18) req = 2'b00;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_resumed", 32'(resumed > 0), 32'd1);
        chk("drain_cnt0", 32'(xfer_cnt[3:0]), 32'(m_cnt[0] % 16));
        chk("drain_cnt1", 32'(xfer_cnt[7:4]), 32'(m_cnt[1] % 16));
`else
        // Without arbitration both eligible channels are acked in the same cycle
        ack_dly = '0;
        data = {8'h9B, 8'h4E};
        req = 2'b11;
        @(negedge clk);
        chk("both_ack", 32'(ack), 32'b11);
        req = 2'b00;
        @(negedge clk);
        m_cnt[0]++; m_last[0] = 8'h4E;
        m_cnt[1]++; m_last[1] = 8'h9B;
        chk("both_cnt0", 32'(xfer_cnt[3:0]), 32'(m_cnt[0] % 16));
        chk("both_cnt1", 32'(xfer_cnt[7:4]), 32'(m_cnt[1] % 16));
        chk("both_last", 32'(last_data), 32'h9B4E);
        chk("both_no_valid", 32'({out_valid, out_chan, out_data}), 32'd0);
`endif

        // Reset asserted in the middle of an ACK cycle
        pulse_reset();
        out_ready = 1'b0;
        ack_dly = '0;
        data = {8'hE1, 8'h1E};
        req[0] = 1'b1;
        found = 0;
        for (int c = 1; c <= 5 && found == 0; c++) begin
            @(negedge clk);
            if (ack[0]) begin found = 1; req[0] = 1'b0; end
        end
        chk("rst_pre_ack0_seen", 32'(found), 32'd1);
        @(negedge clk);
        chk("rst_pre_cnt0", 32'(xfer_cnt[3:0]), 32'd1);
`ifdef HS_SINK_FIFO_EN
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
`endif
        ack_dly = 4'd2;
        req[1] = 1'b1;
        found = 0;
        for (int c = 1; c <= 6 && found == 0; c++) begin
            @(negedge clk);
            if (ack[1]) found = 1;
        end
        chk("rst_ack1_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_xfer", 32'(xfer_cnt), 32'd0);
        chk("rst_mid_last", 32'(last_data), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_after_xfer", 32'(xfer_cnt), 32'd0);
        chk("rst_after_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // 17 transfers on channel 0 wrap a 4-bit counter to 1
        ack_dly = '0;
        data[7:0] = 8'h42;
        req[0] = 1'b1;
        n = 0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (ack[0]) n++;
            if (c == 34) req[0] = 1'b0;
        end
        @(negedge clk);
        m_cnt[0] = 17;
        m_last[0] = 8'h42;
        chk("wrap_acks", 32'(n), 32'd17);
        chk("wrap_xfer_cnt", 32'(xfer_cnt[3:0]), 32'd1);

        // Randomised single-channel transactions against the latency rule
        for (int it = 0; it < 30; it++) begin
            ch   = int'($urandom_range(0, 1));
            dly  = int'($urandom_range(0, 7));
            d    = 8'($urandom);
            drop = 0;
            if (dly > 0 && $urandom_range(0, 3) == 0) drop = int'($urandom_range(1, dly));
            exp  = (drop != 0) ? 0 : dly + 1;
            run_txn(ch, dly, d, drop, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
